// File: rtl/ahb_to_apb_bridge_if.sv
// Signal bundle between the AHB-Lite bus, the bridge and the APB peripherals.
// The slave modport is the bridge's view; the master modport is the environment's view.
interface ahb_to_apb_bridge_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic                  hresp;
   logic [DATA_WIDTH-1:0] hrdata;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready, prdata, pready, pslverr,
      output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hwdata, hready, prdata, pready, pslverr,
      input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge, one transfer outstanding, single clock.
// Optional ACCESS-phase timeout is built when APB_TIMEOUT_EN is defined.
module ahb_to_apb_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   ahb_to_apb_bridge_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WLATCH = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_ERR1   = 3'd4;
   localparam logic [2:0] S_ERR2   = 3'd5;

   logic [2:0]            state;
   logic [2:0]            state_nx;
   logic [2:0]            accept_nx;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  pwrite_q;
   logic                  accept;
   logic                  done;
   logic                  can_accept;
   logic                  take;
   logic                  timeout;

   assign accept     = bus.hsel && bus.hready && bus.htrans[1];
   assign done       = (state == S_ACCESS) && bus.pready && !bus.pslverr;
   assign can_accept = (state == S_IDLE) || (state == S_ERR2) || done;
   assign take       = accept && can_accept;
   assign accept_nx  = take ? (bus.hwrite ? S_WLATCH : S_SETUP) : S_IDLE;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             unused_ok;

   // Fires on the wait cycle that brings the count up to the limit; PREADY has priority.
   assign timeout = (state == S_ACCESS) && !bus.pready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == S_SETUP) begin
         wait_cnt <= '0;
      end else if ((state == S_ACCESS) && !bus.pready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign unused_ok = &{1'b0, bus.hsize};
`else
   logic unused_ok;

   assign timeout   = 1'b0;
   assign unused_ok = &{1'b0, bus.hsize, TIMEOUT_CYCLES > 0};
`endif

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_ERR2: state_nx = accept_nx;
         S_WLATCH:       state_nx = S_SETUP;
         S_SETUP:        state_nx = S_ACCESS;
         S_ACCESS: begin
            if (bus.pready) begin
               state_nx = bus.pslverr ? S_ERR1 : accept_nx;
            end else if (timeout) begin
               state_nx = S_ERR1;
            end
         end
         S_ERR1:         state_nx = S_ERR2;
         default:        state_nx = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            paddr_q  <= bus.haddr;
            pwrite_q <= bus.hwrite;
         end
         if (state == S_WLATCH) begin
            pwdata_q <= bus.hwdata;
         end
      end
   end

   // Outputs decode straight from the async-reset state, so reset drops PSEL at once.
   assign bus.psel      = (state == S_SETUP) || (state == S_ACCESS);
   assign bus.penable   = (state == S_ACCESS);
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.hresp     = (state == S_ERR1) || (state == S_ERR2);
   assign bus.hreadyout = (state == S_IDLE) || (state == S_ERR2) || done;
   assign bus.hrdata    = (done && !pwrite_q) ? bus.prdata : '0;
endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Self-checking bench for ahb_to_apb_bridge: directed scenarios plus randomized
// transfer sequences checked against a cycle-schedule model of the bridge.
module tb_ahb_to_apb_bridge;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      bit          err;
      int          gap;
   } xfer_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   xfer_t q[$];
   int    a_c[64];
   int    comp_c[64];
   int    end_c[64];
   bit    tmo_c[64];
   bit    bad_c[64];

   ahb_to_apb_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ahb_to_apb_bridge #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Single slave on the bus: the bus-wide HREADY is this bridge's HREADYOUT.
   assign bus.hready = bus.hreadyout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_no_accept();
      int r;
      r = $urandom_range(2);
      bus.hsel   = (r != 2);
      bus.htrans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : {1'b1, 1'($urandom)};
      bus.haddr  = $urandom;
      bus.hwrite = 1'($urandom);
      bus.hsize  = 3'($urandom);
   endtask

   // Model: each transfer's cycles are laid out from the latency rules, then every
   // cycle's outputs are compared against what the schedule says.
   task automatic run_queue(input string tag);
      int n, cur, total, ap, act, st, cmp;
      logic        e_psel, e_pen, e_rdy, e_resp;
      logic [31:0] e_rdata;
      n   = q.size();
      cur = 0;
      for (int i = 0; i < n; i++) begin
         a_c[i]    = cur + q[i].gap;
         tmo_c[i]  = TMO_EN && (q[i].waits >= TO);
         comp_c[i] = a_c[i] + (q[i].write ? 3 : 2) + (tmo_c[i] ? TO - 1 : q[i].waits);
         bad_c[i]  = q[i].err || tmo_c[i];
         end_c[i]  = bad_c[i] ? comp_c[i] + 2 : comp_c[i];
         cur       = end_c[i];
      end
      total = cur + 2;
      for (int t = 0; t <= total; t++) begin
         @(posedge clk);
         #1;
         ap  = -1;
         act = -1;
         for (int i = 0; i < n; i++) begin
            if (a_c[i] == t) ap = i;
            if (t > a_c[i] && t <= end_c[i]) act = i;
         end
         drive_no_accept();
         if (ap >= 0) begin
            bus.hsel   = 1'b1;
            bus.htrans = {1'b1, 1'($urandom)};
            bus.haddr  = q[ap].addr;
            bus.hwrite = q[ap].write;
         end
         bus.hwdata  = $urandom;
         bus.prdata  = $urandom;
         bus.pready  = 1'($urandom);
         bus.pslverr = 1'($urandom);
         e_psel  = 1'b0;
         e_pen   = 1'b0;
         e_rdy   = 1'b1;
         e_resp  = 1'b0;
         e_rdata = '0;
         if (act >= 0) begin
            st  = a_c[act] + (q[act].write ? 2 : 1);
            cmp = comp_c[act];
            if (q[act].write) bus.hwdata = q[act].wdata;
            if (t > st && t < cmp) bus.pready = 1'b0;
            if (t == cmp) begin
               bus.pready  = !tmo_c[act];
               bus.pslverr = q[act].err;
               bus.prdata  = q[act].rdata;
            end
            e_rdy = 1'b0;
            if (t >= st && t <= cmp) e_psel = 1'b1;
            if (t > st && t <= cmp) e_pen = 1'b1;
            if (t == cmp && !bad_c[act]) begin
               e_rdy = 1'b1;
               if (!q[act].write) e_rdata = q[act].rdata;
            end
            if (t > cmp) begin
               e_resp = 1'b1;
               e_rdy  = (t == cmp + 2);
            end
         end
         @(negedge clk);
         checks++;
         if (bus.psel !== e_psel) begin
            errors++;
            $display("FAIL %s t=%0d psel got %b exp %b", tag, t, bus.psel, e_psel);
         end
         checks++;
         if (bus.penable !== e_pen) begin
            errors++;
            $display("FAIL %s t=%0d penable got %b exp %b", tag, t, bus.penable, e_pen);
         end
         checks++;
         if (bus.hreadyout !== e_rdy) begin
            errors++;
            $display("FAIL %s t=%0d hreadyout got %b exp %b", tag, t, bus.hreadyout, e_rdy);
         end
         checks++;
         if (bus.hresp !== e_resp) begin
            errors++;
            $display("FAIL %s t=%0d hresp got %b exp %b", tag, t, bus.hresp, e_resp);
         end
         checks++;
         if (bus.hrdata !== e_rdata) begin
            errors++;
            $display("FAIL %s t=%0d hrdata got %h exp %h", tag, t, bus.hrdata, e_rdata);
         end
         if (e_psel) begin
            checks++;
            if (bus.paddr !== q[act].addr) begin
               errors++;
               $display("FAIL %s t=%0d paddr got %h exp %h", tag, t, bus.paddr, q[act].addr);
            end
            checks++;
            if (bus.pwrite !== q[act].write) begin
               errors++;
               $display("FAIL %s t=%0d pwrite got %b exp %b", tag, t, bus.pwrite, q[act].write);
            end
            if (q[act].write) begin
               checks++;
               if (bus.pwdata !== q[act].wdata) begin
                  errors++;
                  $display("FAIL %s t=%0d pwdata got %h exp %h", tag, t, bus.pwdata, q[act].wdata);
               end
            end
         end
      end
      q.delete();
   endtask

   task automatic add(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input bit err, input int gap);
      xfer_t x;
      x.write = w; x.addr = addr; x.wdata = wd; x.rdata = rd;
      x.waits = waits; x.err = err; x.gap = gap;
      q.push_back(x);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = '0; bus.hwrite = 1'b0;
      bus.hsize = 3'b010; bus.hwdata = '0; bus.prdata = '0; bus.pready = 1'b0;
      bus.pslverr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.pwrite} !== 5'b10000) begin
         errors++;
         $display("FAIL reset ctrl got %b exp 10000",
                  {bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.pwrite});
      end
      checks++;
      if ({bus.hrdata, bus.paddr, bus.pwdata} !== 96'h0) begin
         errors++;
         $display("FAIL reset data got %h exp 0", {bus.hrdata, bus.paddr, bus.pwdata});
      end
      rst = 1'b0;
   endtask

   task automatic test_ignored();
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         drive_no_accept();
         bus.pready  = 1'($urandom);
         bus.pslverr = 1'($urandom);
         bus.prdata  = $urandom;
         @(negedge clk);
         checks++;
         if ({bus.psel, bus.penable, bus.hreadyout, bus.hresp} !== 4'b0010 || bus.hrdata !== '0) begin
            errors++;
            $display("FAIL ignored i=%0d psel/pen/rdy/resp got %b exp 0010 hrdata %h",
                     i, {bus.psel, bus.penable, bus.hreadyout, bus.hresp}, bus.hrdata);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #1;
      bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h80; bus.hwrite = 1'b0;
      bus.pready = 1'b0;
      @(posedge clk);
      #1;
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.psel, bus.penable, bus.hreadyout} !== 3'b110) begin
         errors++;
         $display("FAIL rst_mid access got %b exp 110", {bus.psel, bus.penable, bus.hreadyout});
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({bus.psel, bus.penable, bus.hreadyout, bus.hresp} !== 4'b0010) begin
         errors++;
         $display("FAIL rst_mid async got %b exp 0010",
                  {bus.psel, bus.penable, bus.hreadyout, bus.hresp});
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.pready = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.psel, bus.penable, bus.hreadyout, bus.hresp} !== 4'b0010 || bus.hrdata !== '0) begin
         errors++;
         $display("FAIL rst_mid after got %b exp 0010 hrdata %h",
                  {bus.psel, bus.penable, bus.hreadyout, bus.hresp}, bus.hrdata);
      end
      add(1'b0, 32'h84, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 0);
      run_queue("rst_mid_recover");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         add(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
             $urandom_range(3), ($urandom_range(5) == 0), $urandom_range(2));
      end
      run_queue("random");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      add(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 0);
      run_queue("read_zero_wait");
      add(1'b1, 32'h44, 32'h1234_5678, 32'h0, 3, 1'b0, 0);
      run_queue("write_waits");
      add(1'b0, 32'h48, 32'h0, 32'h5555_AAAA, 0, 1'b1, 0);
      run_queue("error");
      add(1'b1, 32'h10, 32'hCAFE_0010, 32'h0, 0, 1'b0, 0);
      add(1'b0, 32'h14, 32'h0, 32'hA5A5_0014, 0, 1'b0, 0);
      add(1'b0, 32'h18, 32'h0, 32'h0000_0018, 1, 1'b1, 0);
      add(1'b1, 32'h1C, 32'h7777_001C, 32'h0, 0, 1'b0, 0);
      run_queue("back_to_back");
      test_ignored();
      add(1'b0, 32'h60, 32'h0, 32'h6060_6060, 6, 1'b0, 0);
      add(1'b1, 32'h64, 32'h6464_6464, 32'h0, TO - 1, 1'b0, 1);
      run_queue("timeout");
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
